gcd_apb_driver: RTL and testbench
=================================

# gcd_apb_driver

APB master that drives the memory-mapped GCD calculator slave on behalf of a streaming client. It takes (a, b) jobs on a valid/ready input and runs the APB sequence: initialise control, poll or wait for the core, write operands, read the result. The GCD is returned on a valid/ready output. It sits directly upstream of the APB GCD slave and connects point-to-point to its APB port and interrupt.

## Interface
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- POLL_MAX, 255, timeout limit per wait phase: status reads (poll mode) or cycles (interrupt mode); ≥1
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_valid  in  1  job valid
- s_ready  out  1  job accepted when s_valid & s_ready
- s_a  in  8  operand a
- s_b  in  8  operand b
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid & m_ready
- m_gcd  out  8  result; 0 on error
- m_err  out  1  result qualifier: timeout occurred
- o_psel, o_penable, o_pwrite  out  1  APB controls
- o_paddr  out  ADDR_W  APB address
- o_pwdata  out  DATA_W  APB write data
- i_prdata  in  DATA_W  APB read data
- i_pready  in  1  APB ready
- i_intr  in  1  slave interrupt; used only with GCD_DRV_INTR_EN
- o_busy  out  1  high whenever FSM not in IDLE

## Operation
- Slave map: 0x00 control {type[2], intr_en[1], enable[0]}; 0x04 status {data_in_ready[1], data_out_valid[0]}; 0x08 data_in {a[15:8], b[7:0]}; 0x0C data_out {gcd[7:0]}.
- APB transfer engine:
  - SETUP: psel=1, penable=0, for 1 cycle.
  - ACCESS: psel=1, penable=1, held until i_pready is sampled high; no pready timeout.
  - Read data is captured on the completing cycle.
  - One idle cycle with psel=0 follows every transfer.
  - paddr, pwrite and pwdata are stable from SETUP through completion.
  - pwdata is 0 on reads.
- FSM states and transitions:
  - INIT: write 0x00 = CTRL_VAL.
  - IDLE: s_ready=1.
  - POLL_IN: read 0x04 until bit1=1.
  - WR_DATA: write 0x08 = {16'h0, a, b}.
  - WAIT_OUT:
    - Without macro: read 0x04 until bit0=1.
    - With macro: wait for i_intr=1.
  - RD_DATA: read 0x0C and latch bits[7:0].
  - OUT: m_valid=1 until m_ready.
  - RECOV_CLR: write 0x00=0.
  - RECOV_SET: write 0x00=CTRL_VAL, then go to OUT with m_err=1, m_gcd=0.
- Operands are latched at acceptance; s_a/s_b are ignored afterwards.
- Timeout counter:
  - Cleared on entry to POLL_IN and to WAIT_OUT.
  - Reaching POLL_MAX without the awaited condition → RECOV_CLR.
  - Recovery resets the core through its enable bit.
- Operands 0 are not special-cased; the core result is passed through unchanged.
- Output exits:
  - OUT → IDLE on m_ready.
  - m_valid and s_ready are never high in the same cycle; this gives one job in flight.
- Reset values: s_ready=0, m_valid=0, m_gcd=0, m_err=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, o_busy=1 (INIT pending).
- Reset mid-transfer: all APB outputs drop in the next cycle; any in-flight job is discarded; INIT reruns.

## Timing
- INIT:
  - First cycle after rstn release: SETUP write to 0x00.
  - Completes with the slave's 2-cycle write.
  - s_ready=1 on the 4th cycle after release.
- Slave write = 2 cycles (SETUP + 1 ACCESS); slave read = 3 cycles (SETUP + 2 ACCESS).
- Minimum job latency, acceptance to m_valid, in poll mode with immediate status hits: poll read 4 + write 3 + poll read 4 + data read 4.
- m_valid rises one cycle after RD_DATA completes.
- m_gcd and m_err are stable while m_valid=1.

## Configuration
- GCD_DRV_INTR_EN defined:
  - CTRL_VAL=0x3 (enabled, level interrupt).
  - WAIT_OUT idles the APB until i_intr=1, then proceeds to RD_DATA.
  - Timeout counts cycles.
- GCD_DRV_INTR_EN undefined:
  - CTRL_VAL=0x1.
  - WAIT_OUT polls status.
  - i_intr is ignored.
  - Timeout counts status reads.

## Test plan
- Reset release → write 0x00=0x1 with psel/penable 1/0 then 1/1; s_ready rises on cycle 4; all outputs 0 during reset.
- Job a=12, b=18 → APB sequence read 0x04, write 0x08=0x0000_0C12, read 0x04, read 0x0C; result m_gcd=6, m_err=0.
- Jobs (48,36) then (17,5) back-to-back with m_ready=1 → results 12 then 1; s_ready low for the whole duration of each job.
- m_ready held low 10 cycles after m_valid → m_valid and m_gcd=6 held; s_ready=0; no APB activity.
- Slave model with status stuck at 0 and POLL_MAX=4 → 4 status reads, write 0x00=0, write 0x00=CTRL_VAL; result m_valid with m_err=1, m_gcd=0.
- rstn asserted during an ACCESS read → psel=penable=0 next cycle; after release the INIT write reruns and the lost job is not output.

Source files
------------

// File: rtl/gcd_apb_driver.sv
// gcd_apb_driver: APB master that runs (a, b) jobs on the memory-mapped GCD slave.
// Each job does: poll status for input ready, write operands, wait for the result,
// read the result. A timeout in either wait phase resets the core through its enable
// bit, and the job completes with m_err=1.
// Optional feature macro GCD_DRV_INTR_EN: wait on i_intr instead of polling for the result.
module gcd_apb_driver #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_a,
  input  logic [7:0]        s_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_gcd,
  output logic              m_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_intr,
  output logic              o_busy
);

  // Counter holds 0..POLL_MAX-1; reaching the last value without a hit means timeout.
  localparam int unsigned CNT_W = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_MAX - 1);

`ifdef GCD_DRV_INTR_EN
  localparam logic [DATA_W-1:0] CTRL_VAL = DATA_W'(3);
`else
  localparam logic [DATA_W-1:0] CTRL_VAL = DATA_W'(1);
`endif

  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_DIN  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_DOUT = ADDR_W'(8'h0C);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_POLL_IN, S_WR_DATA, S_WAIT_OUT,
    S_RD_DATA, S_OUT, S_RECOV_CLR, S_RECOV_SET
  } state_t;

  // PH_START: transfer not yet begun; PH_DONE: the psel=0 idle cycle after completion,
  // during which the FSM decides on the captured data and may launch the next SETUP.
  typedef enum logic [1:0] {PH_START, PH_SETUP, PH_ACCESS, PH_DONE} phase_t;

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         a_q, a_d, b_q, b_d;
  logic [7:0]         rd_q, rd_d;
  logic [7:0]         gcd_q, gcd_d;
  logic               err_q, err_d;
  logic               done;

  logic               req_xfer, req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;

  logic               unused_ok;
  assign unused_ok = ^{i_prdata, i_intr};

  // Decode the APB transfer the current state performs.
  always_comb begin
    req_xfer  = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state_q)
      S_INIT:      begin req_xfer = 1'b1; req_wr = 1'b1; req_addr = A_CTRL; req_wdata = CTRL_VAL; end
      S_POLL_IN:   begin req_xfer = 1'b1; req_addr = A_STAT; end
      S_WR_DATA:   begin req_xfer = 1'b1; req_wr = 1'b1; req_addr = A_DIN; req_wdata = DATA_W'({a_q, b_q}); end
      S_WAIT_OUT:  begin
`ifndef GCD_DRV_INTR_EN
        req_xfer = 1'b1; req_addr = A_STAT;
`endif
      end
      S_RD_DATA:   begin req_xfer = 1'b1; req_addr = A_DOUT; end
      S_RECOV_CLR: begin req_xfer = 1'b1; req_wr = 1'b1; req_addr = A_CTRL; req_wdata = '0; end
      S_RECOV_SET: begin req_xfer = 1'b1; req_wr = 1'b1; req_addr = A_CTRL; req_wdata = CTRL_VAL; end
      default:     ;
    endcase
  end

  assign done      = (phase_q == PH_DONE);
  assign o_psel    = (phase_q == PH_SETUP) || (phase_q == PH_ACCESS);
  assign o_penable = (phase_q == PH_ACCESS);
  assign o_pwrite  = o_psel & req_wr;
  assign o_paddr   = o_psel ? req_addr : '0;
  assign o_pwdata  = (o_psel && req_wr) ? req_wdata : '0;
  assign s_ready   = (state_q == S_IDLE);
  assign m_valid   = (state_q == S_OUT);
  assign o_busy    = (state_q != S_IDLE);
  assign m_gcd     = gcd_q;
  assign m_err     = err_q;

  // Transfer engine plus job FSM: next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    gcd_d   = gcd_q;
    err_d   = err_q;

    case (phase_q)
      PH_START:  if (req_xfer) phase_d = PH_SETUP;
      PH_SETUP:  phase_d = PH_ACCESS;
      PH_ACCESS: if (i_pready) begin phase_d = PH_DONE; rd_d = i_prdata[7:0]; end
      default:   ;
    endcase

    case (state_q)
      S_INIT: if (done) begin state_d = S_IDLE; phase_d = PH_START; end
      S_IDLE: if (s_valid) begin
        a_d = s_a; b_d = s_b; cnt_d = '0;
        state_d = S_POLL_IN; phase_d = PH_SETUP;
      end
      S_POLL_IN: if (done) begin
        phase_d = PH_SETUP;
        if (rd_q[1])                state_d = S_WR_DATA;
        else if (cnt_q == CNT_LAST) state_d = S_RECOV_CLR;
        else                        cnt_d = cnt_q + 1'b1;
      end
      S_WR_DATA: if (done) begin
        state_d = S_WAIT_OUT;
        cnt_d   = '0;
`ifdef GCD_DRV_INTR_EN
        phase_d = PH_START;
`else
        phase_d = PH_SETUP;
`endif
      end
      S_WAIT_OUT: begin
`ifdef GCD_DRV_INTR_EN
        if (i_intr) begin state_d = S_RD_DATA; phase_d = PH_SETUP; end
        else if (cnt_q == CNT_LAST) begin state_d = S_RECOV_CLR; phase_d = PH_SETUP; end
        else cnt_d = cnt_q + 1'b1;
`else
        if (done) begin
          phase_d = PH_SETUP;
          if (rd_q[0])                state_d = S_RD_DATA;
          else if (cnt_q == CNT_LAST) state_d = S_RECOV_CLR;
          else                        cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RD_DATA: if (done) begin
        state_d = S_OUT; phase_d = PH_START; gcd_d = rd_q; err_d = 1'b0;
      end
      S_OUT: if (m_ready) state_d = S_IDLE;
      S_RECOV_CLR: if (done) begin state_d = S_RECOV_SET; phase_d = PH_SETUP; end
      S_RECOV_SET: if (done) begin
        state_d = S_OUT; phase_d = PH_START; gcd_d = '0; err_d = 1'b1;
      end
      default: begin state_d = S_INIT; phase_d = PH_START; end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_INIT;
      phase_q <= PH_START;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      gcd_q   <= gcd_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gcd_apb_driver.sv
// tb_gcd_apb_driver: self-checking bench with an APB GCD slave model and a result scoreboard.
module tb_gcd_apb_driver;

  localparam int unsigned POLL_MAX = 4;
`ifdef GCD_DRV_INTR_EN
  localparam logic [31:0] CTRL = 32'h3;
`else
  localparam logic [31:0] CTRL = 32'h1;
`endif

  typedef struct packed {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk, rstn;
  logic        s_valid, s_ready, m_valid, m_ready, m_err;
  logic [7:0]  s_a, s_b, m_gcd;
  logic        psel, penable, pwrite, pready, intr, busy;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  xfer_t       log_q[$];

  logic [1:0]  acc_cnt  = '0;
  logic [7:0]  dout     = '0;
  logic        have_res = 1'b0;
  logic        stuck    = 1'b0;

  gcd_apb_driver #(.ADDR_W(8), .DATA_W(32), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_gcd(m_gcd), .m_err(m_err),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr),
    .o_pwdata(pwdata), .i_prdata(prdata), .i_pready(pready), .i_intr(intr),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gcd8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] a, b, t;
    a = x; b = y;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // Slave: writes complete in 2 cycles, reads in 3.
  assign pready = psel && penable && (pwrite || acc_cnt == 2'd1);
  assign intr   = have_res && !stuck;
  always_comb begin
    prdata = '0;
    if (paddr == 8'h04)      prdata = {30'h0, stuck ? 2'b00 : 2'b11};
    else if (paddr == 8'h0C) prdata = {24'h0, dout};
  end

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 2'd1;
    else                            acc_cnt <= '0;
    if (psel && penable && pready) begin
      log_q.push_back({pwrite, paddr, pwdata});
      if (pwrite && paddr == 8'h08) begin dout <= gcd8(pwdata[15:8], pwdata[7:0]); have_res <= 1'b1; end
      if (!pwrite && paddr == 8'h0C) have_res <= 1'b0;
    end
  end

  task automatic send_job(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp, output bit ok);
    int n;
    n = 0;
    s_a = a; s_b = b; s_valid = 1'b1;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    ok = s_ready;
    if (ok) exp_q.push_back(exp);
    @(negedge clk);
    s_valid = 1'b0; s_a = ~a; s_b = ~b;
  endtask

  task automatic wait_mvalid(output bit ok, output bit sready_seen, output bit overlap);
    int n;
    n = 0; sready_seen = 0; overlap = 0;
    while (!m_valid && n < 200) begin
      if (s_ready) sready_seen = 1;
      @(negedge clk); n++;
    end
    ok = m_valid;
    if (m_valid && s_ready) overlap = 1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata} !== 43'h0) begin
      n_err++; $display("FAIL reset_apb got %h want 0", {psel, penable, pwrite, paddr, pwdata});
    end
    n_cmp++;
    if ({s_ready, m_valid, m_gcd, m_err, busy} !== 12'h001) begin
      n_err++; $display("FAIL reset_stream got %h want 001", {s_ready, m_valid, m_gcd, m_err, busy});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 8'h00, CTRL}) begin
      n_err++; $display("FAIL init_setup got %h want %h", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b0, 1'b1, 8'h00, CTRL});
    end
    @(negedge clk);
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b1, 1'b1, 8'h00, CTRL}) begin
      n_err++; $display("FAIL init_access got %h want %h", {psel, penable, pwrite, paddr, pwdata}, {1'b1, 1'b1, 1'b1, 8'h00, CTRL});
    end
    @(negedge clk);
    n_cmp++;
    if ({psel, s_ready} !== 2'b00) begin
      n_err++; $display("FAIL init_gap psel/s_ready got %b want 00", {psel, s_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({s_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL init_ready s_ready/busy got %b want 10", {s_ready, busy});
    end
  endtask

  task automatic test_single_job;
    bit ok, seen, ovl;
    logic [8:0] e;
    xfer_t exp_log[4];
    exp_log = '{{1'b0, 8'h04, 32'h0}, {1'b1, 8'h08, 32'h0000_0C12}, {1'b0, 8'h04, 32'h0}, {1'b0, 8'h0C, 32'h0}};
    log_q.delete();
    m_ready = 1'b1;
    send_job(8'd12, 8'd18, {8'd6, 1'b0}, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL single_accept got s_ready=0 want 1"); end
    wait_mvalid(ok, seen, ovl);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin
      n_err++; $display("FAIL single_result got m_valid=%b want 1", m_valid);
    end else begin
      e = exp_q.pop_front();
      if ({m_gcd, m_err} !== e) begin n_err++; $display("FAIL single_result got %h want %h", {m_gcd, m_err}, e); end
    end
    @(negedge clk);
    n_cmp++;
    if (log_q.size() != 4) begin
      n_err++; $display("FAIL single_seq_len got %0d want 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (log_q[i] !== exp_log[i]) begin
          n_err++; $display("FAIL single_seq[%0d] got %h want %h", i, log_q[i], exp_log[i]);
          break;
        end
    end
  endtask

  task automatic test_back_to_back;
    bit ok, seen, ovl;
    logic [8:0] e;
    logic [7:0] ja[2], jb[2], jg[2];
    ja = '{8'd48, 8'd17}; jb = '{8'd36, 8'd5}; jg = '{8'd12, 8'd1};
    m_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      send_job(ja[j], jb[j], {jg[j], 1'b0}, ok);
      wait_mvalid(ok, seen, ovl);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL b2b_result[%0d] got m_valid=%b want 1", j, m_valid);
      end else begin
        e = exp_q.pop_front();
        if ({m_gcd, m_err} !== e) begin n_err++; $display("FAIL b2b_result[%0d] got %h want %h", j, {m_gcd, m_err}, e); end
      end
      n_cmp++;
      if (seen || ovl) begin
        n_err++; $display("FAIL b2b_sready[%0d] got seen=%b overlap=%b want 0 0", j, seen, ovl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit ok, seen, ovl, bad;
    logic [8:0] e;
    m_ready = 1'b0;
    send_job(8'd12, 8'd18, {8'd6, 1'b0}, ok);
    wait_mvalid(ok, seen, ovl);
    log_q.delete();
    bad = !ok;
    for (int i = 0; i < 10; i++) begin
      if (!m_valid || m_gcd !== 8'd6 || s_ready || psel) bad = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad || log_q.size() != 0) begin
      n_err++; $display("FAIL hold got m_valid=%b m_gcd=%0d s_ready=%b xfers=%0d want 1 6 0 0", m_valid, m_gcd, s_ready, log_q.size());
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL hold_result got empty scoreboard want entry");
    end else begin
      e = exp_q.pop_front();
      if ({m_gcd, m_err} !== e) begin n_err++; $display("FAIL hold_result got %h want %h", {m_gcd, m_err}, e); end
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_valid, s_ready} !== 2'b01) begin
      n_err++; $display("FAIL hold_release got %b want 01", {m_valid, s_ready});
    end
  endtask

  task automatic test_timeout;
    bit ok, seen, ovl;
    logic [8:0] e;
    xfer_t exp_log[6];
    exp_log = '{{1'b0, 8'h04, 32'h0}, {1'b0, 8'h04, 32'h0}, {1'b0, 8'h04, 32'h0},
                {1'b0, 8'h04, 32'h0}, {1'b1, 8'h00, 32'h0}, {1'b1, 8'h00, CTRL}};
    stuck = 1'b1;
    m_ready = 1'b1;
    log_q.delete();
    send_job(8'd9, 8'd6, {8'd0, 1'b1}, ok);
    wait_mvalid(ok, seen, ovl);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin
      n_err++; $display("FAIL timeout_result got m_valid=%b want 1", m_valid);
    end else begin
      e = exp_q.pop_front();
      if ({m_gcd, m_err} !== e) begin n_err++; $display("FAIL timeout_result got %h want %h", {m_gcd, m_err}, e); end
    end
    @(negedge clk);
    n_cmp++;
    if (log_q.size() != 6) begin
      n_err++; $display("FAIL timeout_seq_len got %0d want 6", log_q.size());
    end else begin
      for (int i = 0; i < 6; i++)
        if (log_q[i] !== exp_log[i]) begin
          n_err++; $display("FAIL timeout_seq[%0d] got %h want %h", i, log_q[i], exp_log[i]);
          break;
        end
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok, seen_out;
    int n;
    m_ready = 1'b1;
    send_job(8'd20, 8'd8, {8'd4, 1'b0}, ok);
    n = 0;
    while (!(psel && penable && !pwrite) && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (!(psel && penable && !pwrite)) begin
      n_err++; $display("FAIL midrst_access got psel=%b penable=%b want read access", psel, penable);
    end
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if ({psel, penable} !== 2'b00) begin
      n_err++; $display("FAIL midrst_drop got %b want 00", {psel, penable});
    end
    @(negedge clk);
    rstn = 1'b1;
    log_q.delete();
    seen_out = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_valid) seen_out = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_out || !s_ready) begin
      n_err++; $display("FAIL midrst_discard got m_valid_seen=%b s_ready=%b want 0 1", seen_out, s_ready);
    end
    n_cmp++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 8'h00, CTRL}) begin
      n_err++; $display("FAIL midrst_init got %0d xfers first=%h want 1 %h", log_q.size(),
                        (log_q.size() > 0) ? log_q[0] : 41'h0, {1'b1, 8'h00, CTRL});
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
